// File: rtl/control_unit_pkg.sv
// Shared encodings for the basic-computer control unit: bus sources, ALU ops,
// opcodes, sequence steps and register-reference bit positions.
package control_unit_pkg;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  localparam logic [2:0] ALU_AND     = 3'd0;
  localparam logic [2:0] ALU_ADD     = 3'd1;
  localparam logic [2:0] ALU_PASS_DR = 3'd2;
  localparam logic [2:0] ALU_CMA     = 3'd3;
  localparam logic [2:0] ALU_CIR     = 3'd4;
  localparam logic [2:0] ALU_CIL     = 3'd5;
  localparam logic [2:0] ALU_INC     = 3'd6;

  localparam logic [2:0] D0 = 3'd0;
  localparam logic [2:0] D1 = 3'd1;
  localparam logic [2:0] D2 = 3'd2;
  localparam logic [2:0] D3 = 3'd3;
  localparam logic [2:0] D4 = 3'd4;
  localparam logic [2:0] D5 = 3'd5;
  localparam logic [2:0] D6 = 3'd6;
  localparam logic [2:0] D7 = 3'd7;

  localparam int RR_CLA = 11;
  localparam int RR_CLE = 10;
  localparam int RR_CMA = 9;
  localparam int RR_CME = 8;
  localparam int RR_CIR = 7;
  localparam int RR_CIL = 6;
  localparam int RR_INC = 5;
  localparam int RR_SPA = 4;
  localparam int RR_SNA = 3;
  localparam int RR_SZA = 2;
  localparam int RR_SZE = 1;
  localparam int RR_HLT = 0;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } step_e;

endpackage

// File: rtl/control_unit_seq_counter.sv
// Instruction step counter: synchronous reset/clear, increment saturating at T6,
// otherwise hold.
module seq_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [2:0] o_t
);

  logic [2:0] r_t;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_t <= 3'd0;
    end else if (i_inc && (r_t != 3'd6)) begin
      r_t <= r_t + 3'd1;
    end
  end

  assign o_t = r_t;

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: decodes step, indirect flag, IR and AC/DR/E flags into
// combinational register/bus/memory strobes; holds in T0 once halted.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] IR,
  input  logic         AC_zero,
  input  logic         AC_msb,
  input  logic         DR_zero,
  input  logic         E,
  output logic [2:0]   bus_sel,
  output logic [2:0]   alu_sel,
  output logic         AR_write, AR_increment, AR_clear,
  output logic         PC_write, PC_increment, PC_clear,
  output logic         DR_write, DR_increment, DR_clear,
  output logic         AC_write, AC_increment, AC_clear,
  output logic         TR_write, TR_increment, TR_clear,
  output logic         IR_write,
  output logic         OUTR_write,
  output logic         mem_write,
  output logic         E_clear,
  output logic         E_comp,
  output logic         E_load,
  output logic         halted,
  output logic [2:0]   T
);

  logic          r_i;
  logic          r_s;
  logic [2:0]    w_sc;
  step_e         w_step;
  logic [2:0]    w_d;
  logic [AW-1:0] w_rr;
  logic          w_last;
  logic          w_set_s;
  logic          w_sc_clr;
  logic          w_sc_inc;

  assign w_step   = step_e'(w_sc);
  assign w_d      = IR[W-2:W-4];
  assign w_rr     = IR[AW-1:0];
  assign w_sc_clr = w_last && !r_s;
  assign w_sc_inc = !w_last && !r_s;
  assign T        = w_sc;

  seq_counter u_sc (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_sc_clr),
    .i_inc (w_sc_inc),
    .o_t   (w_sc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i <= 1'b0;
      r_s <= 1'b0;
    end else begin
      if (!r_s && (w_step == T2)) r_i <= IR[W-1];
      if (w_set_s) r_s <= 1'b1;
    end
  end

  always_comb begin
    bus_sel = BUS_NONE;
    alu_sel = ALU_AND;
    {AR_write, AR_increment, AR_clear} = 3'b000;
    {PC_write, PC_increment, PC_clear} = 3'b000;
    {DR_write, DR_increment, DR_clear} = 3'b000;
    {AC_write, AC_increment, AC_clear} = 3'b000;
    {TR_write, TR_increment, TR_clear} = 3'b000;
    IR_write   = 1'b0;
    OUTR_write = 1'b0;
    mem_write  = 1'b0;
    E_clear    = 1'b0;
    E_comp     = 1'b0;
    E_load     = 1'b0;
    halted     = 1'b0;
    w_last     = 1'b0;
    w_set_s    = 1'b0;
    if (reset) begin
      PC_clear = 1'b1;
      AC_clear = 1'b1;
      E_clear  = 1'b1;
    end else if (r_s) begin
      halted = 1'b1;
    end else begin
      case (w_step)
        T0: begin bus_sel = BUS_PC;  AR_write = 1'b1; end
        T1: begin bus_sel = BUS_MEM; IR_write = 1'b1; PC_increment = 1'b1; end
        T2: begin bus_sel = BUS_IR;  AR_write = 1'b1; end
        T3: begin
          if (w_d == D7) begin
            w_last = 1'b1;
            // Register-reference: every set IR bit acts in this one cycle.
            if (!r_i) begin
              AC_clear = w_rr[RR_CLA];
              E_clear  = w_rr[RR_CLE];
              E_comp   = w_rr[RR_CME];
              AC_increment = w_rr[RR_INC];
              if (w_rr[RR_CMA]) begin AC_write = 1'b1; alu_sel = ALU_CMA; end
              if (w_rr[RR_CIR]) begin AC_write = 1'b1; alu_sel = ALU_CIR; E_load = 1'b1; end
              if (w_rr[RR_CIL]) begin AC_write = 1'b1; alu_sel = ALU_CIL; E_load = 1'b1; end
              PC_increment = (w_rr[RR_SPA] && !AC_msb && !AC_zero) ||
                             (w_rr[RR_SNA] && AC_msb) ||
                             (w_rr[RR_SZA] && AC_zero) ||
                             (w_rr[RR_SZE] && !E);
              w_set_s = w_rr[RR_HLT];
            end
          end else if (r_i) begin
            bus_sel  = BUS_MEM;
            AR_write = 1'b1;
          end
        end
        T4: begin
          case (w_d)
            D0, D1, D2, D6: begin bus_sel = BUS_MEM; DR_write = 1'b1; end
            D3: begin bus_sel = BUS_AC; mem_write = 1'b1; w_last = 1'b1; end
            D4: begin bus_sel = BUS_AR; PC_write  = 1'b1; w_last = 1'b1; end
            D5: begin bus_sel = BUS_PC; mem_write = 1'b1; AR_increment = 1'b1; end
            default: w_last = 1'b1;
          endcase
        end
        T5: begin
          case (w_d)
            D0: begin AC_write = 1'b1; alu_sel = ALU_AND; w_last = 1'b1; end
            D1: begin AC_write = 1'b1; alu_sel = ALU_ADD; E_load = 1'b1; w_last = 1'b1; end
            D2: begin AC_write = 1'b1; alu_sel = ALU_PASS_DR; w_last = 1'b1; end
            D5: begin bus_sel = BUS_AR; PC_write = 1'b1; w_last = 1'b1; end
            D6: DR_increment = 1'b1;
            default: w_last = 1'b1;
          endcase
        end
        T6: begin
          bus_sel      = BUS_DR;
          mem_write    = 1'b1;
          PC_increment = DR_zero;
          w_last       = 1'b1;
        end
        default: w_last = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-by-cycle check of control_unit strobes against hand-derived expectations.
module tb_control_unit;
  import control_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] IR = '0;
  logic AC_zero = 1'b0, AC_msb = 1'b0, DR_zero = 1'b0, E = 1'b0;
  logic [2:0] bus_sel, alu_sel, T;
  logic AR_write, AR_increment, AR_clear, PC_write, PC_increment, PC_clear;
  logic DR_write, DR_increment, DR_clear, AC_write, AC_increment, AC_clear;
  logic TR_write, TR_increment, TR_clear, IR_write, OUTR_write, mem_write;
  logic E_clear, E_comp, E_load, halted;

  always #5 clk = ~clk;

  control_unit #(.W(16), .AW(12)) dut (
    .clk(clk), .reset(reset), .IR(IR), .AC_zero(AC_zero), .AC_msb(AC_msb),
    .DR_zero(DR_zero), .E(E), .bus_sel(bus_sel), .alu_sel(alu_sel),
    .AR_write(AR_write), .AR_increment(AR_increment), .AR_clear(AR_clear),
    .PC_write(PC_write), .PC_increment(PC_increment), .PC_clear(PC_clear),
    .DR_write(DR_write), .DR_increment(DR_increment), .DR_clear(DR_clear),
    .AC_write(AC_write), .AC_increment(AC_increment), .AC_clear(AC_clear),
    .TR_write(TR_write), .TR_increment(TR_increment), .TR_clear(TR_clear),
    .IR_write(IR_write), .OUTR_write(OUTR_write), .mem_write(mem_write),
    .E_clear(E_clear), .E_comp(E_comp), .E_load(E_load), .halted(halted), .T(T)
  );

  localparam logic [21:0] F_ARW = 22'd1 << 21, F_ARI = 22'd1 << 20, F_PCW = 22'd1 << 18;
  localparam logic [21:0] F_PCI = 22'd1 << 17, F_PCC = 22'd1 << 16, F_DRW = 22'd1 << 15;
  localparam logic [21:0] F_DRI = 22'd1 << 14, F_ACW = 22'd1 << 12, F_ACI = 22'd1 << 11;
  localparam logic [21:0] F_ACC = 22'd1 << 10, F_IRW = 22'd1 << 6,  F_MEM = 22'd1 << 4;
  localparam logic [21:0] F_EC  = 22'd1 << 3,  F_ECM = 22'd1 << 2,  F_EL  = 22'd1 << 1;
  localparam logic [21:0] F_HLT = 22'd1;
  localparam logic [21:0] F_RST = F_PCC | F_ACC | F_EC;
  localparam logic [30:0] ALL = '1;
  localparam logic [30:0] NO_T = 31'h0FFF_FFFF;

  logic [30:0] obs;
  assign obs = {T, bus_sel, alu_sel, AR_write, AR_increment, AR_clear, PC_write,
                PC_increment, PC_clear, DR_write, DR_increment, DR_clear, AC_write,
                AC_increment, AC_clear, TR_write, TR_increment, TR_clear, IR_write,
                OUTR_write, mem_write, E_clear, E_comp, E_load, halted};

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  fl;   // {AC_zero, AC_msb, DR_zero, E}
    logic [30:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [30:0] sb[$];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic logic [30:0] ex(input logic [2:0] t, input logic [2:0] bus,
                                     input logic [2:0] alu, input logic [21:0] f);
    return {t, bus, alu, f};
  endfunction

  function automatic void add(input logic r, input logic [15:0] ir, input logic [3:0] fl,
                              input logic [2:0] t, input logic [2:0] bus,
                              input logic [2:0] alu, input logic [21:0] f);
    vec_t v;
    v.rst = r; v.ir = ir; v.fl = fl; v.exp = ex(t, bus, alu, f);
    tbl.push_back(v);
  endfunction

  function automatic void fetch(input logic [15:0] ir, input logic [3:0] fl);
    add(0, ir, fl, 3'd0, 3'd2, 3'd0, F_ARW);
    add(0, ir, fl, 3'd1, 3'd7, 3'd0, F_IRW | F_PCI);
    add(0, ir, fl, 3'd2, 3'd5, 3'd0, F_ARW);
  endfunction

  task automatic cyc(input logic r, input logic [15:0] ir, input logic [3:0] fl,
                     input logic [30:0] exp, input logic [30:0] m, input string nm);
    logic [30:0] want;
    @(posedge clk);
    #1;
    reset = r;
    IR = ir;
    {AC_zero, AC_msb, DR_zero, E} = fl;
    sb.push_back(exp);
    @(negedge clk);
    want = sb.pop_front();
    n_chk++;
    if ((obs & m) !== (want & m)) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, obs & m, want & m);
    end
  endtask

  initial begin
    add(1, 16'h0000, 4'b0000, 3'd0, 3'd0, 3'd0, F_RST);
    add(1, 16'h0000, 4'b0000, 3'd0, 3'd0, 3'd0, F_RST);
    fetch(16'h2105, 4'b0000);                                   // LDA direct
    add(0, 16'h2105, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h2105, 4'b0000, 3'd4, 3'd7, 3'd0, F_DRW);
    add(0, 16'h2105, 4'b0000, 3'd5, 3'd0, ALU_PASS_DR, F_ACW);
    fetch(16'h9105, 4'b0000);                                   // ADD indirect
    add(0, 16'h9105, 4'b0000, 3'd3, 3'd7, 3'd0, F_ARW);
    add(0, 16'h9105, 4'b0000, 3'd4, 3'd7, 3'd0, F_DRW);
    add(0, 16'h9105, 4'b0000, 3'd5, 3'd0, ALU_ADD, F_ACW | F_EL);
    fetch(16'h0105, 4'b0000);                                   // AND
    add(0, 16'h0105, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h0105, 4'b0000, 3'd4, 3'd7, 3'd0, F_DRW);
    add(0, 16'h0105, 4'b0000, 3'd5, 3'd0, ALU_AND, F_ACW);
    fetch(16'h6105, 4'b0010);                                   // ISZ, DR becomes 0
    add(0, 16'h6105, 4'b0010, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h6105, 4'b0010, 3'd4, 3'd7, 3'd0, F_DRW);
    add(0, 16'h6105, 4'b0010, 3'd5, 3'd0, 3'd0, F_DRI);
    add(0, 16'h6105, 4'b0010, 3'd6, 3'd3, 3'd0, F_MEM | F_PCI);
    fetch(16'h6105, 4'b0000);                                   // ISZ, no skip
    add(0, 16'h6105, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h6105, 4'b0000, 3'd4, 3'd7, 3'd0, F_DRW);
    add(0, 16'h6105, 4'b0000, 3'd5, 3'd0, 3'd0, F_DRI);
    add(0, 16'h6105, 4'b0000, 3'd6, 3'd3, 3'd0, F_MEM);
    fetch(16'h3105, 4'b0000);                                   // STA
    add(0, 16'h3105, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h3105, 4'b0000, 3'd4, 3'd4, 3'd0, F_MEM);
    fetch(16'h4105, 4'b0000);                                   // BUN
    add(0, 16'h4105, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h4105, 4'b0000, 3'd4, 3'd1, 3'd0, F_PCW);
    fetch(16'h5105, 4'b0000);                                   // BSA
    add(0, 16'h5105, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    add(0, 16'h5105, 4'b0000, 3'd4, 3'd2, 3'd0, F_MEM | F_ARI);
    add(0, 16'h5105, 4'b0000, 3'd5, 3'd1, 3'd0, F_PCW);
    fetch(16'h7004, 4'b1000);                                   // SZA taken
    add(0, 16'h7004, 4'b1000, 3'd3, 3'd0, 3'd0, F_PCI);
    fetch(16'h7004, 4'b0000);                                   // SZA not taken
    add(0, 16'h7004, 4'b0000, 3'd3, 3'd0, 3'd0, '0);
    fetch(16'h7010, 4'b0000);                                   // SPA taken
    add(0, 16'h7010, 4'b0000, 3'd3, 3'd0, 3'd0, F_PCI);
    fetch(16'h7008, 4'b0100);                                   // SNA taken
    add(0, 16'h7008, 4'b0100, 3'd3, 3'd0, 3'd0, F_PCI);
    fetch(16'h7002, 4'b0001);                                   // SZE with E=1
    add(0, 16'h7002, 4'b0001, 3'd3, 3'd0, 3'd0, '0);
    fetch(16'h7C00, 4'b0000);                                   // CLA|CLE
    add(0, 16'h7C00, 4'b0000, 3'd3, 3'd0, 3'd0, F_ACC | F_EC);
    fetch(16'h7220, 4'b0000);                                   // CMA|INC
    add(0, 16'h7220, 4'b0000, 3'd3, 3'd0, ALU_CMA, F_ACW | F_ACI);
    fetch(16'h7180, 4'b0000);                                   // CME|CIR
    add(0, 16'h7180, 4'b0000, 3'd3, 3'd0, ALU_CIR, F_ACW | F_EL | F_ECM);
    fetch(16'hF800, 4'b0000);                                   // I/O acts as NOP
    add(0, 16'hF800, 4'b0000, 3'd3, 3'd0, 3'd0, '0);

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].rst, tbl[i].ir, tbl[i].fl, tbl[i].exp, ALL, $sformatf("row%0d", i));

    cyc(0, 16'h7001, 4'b0000, ex(3'd0, 3'd2, 3'd0, F_ARW), ALL, "hlt_t0");
    cyc(0, 16'h7001, 4'b0000, ex(3'd1, 3'd7, 3'd0, F_IRW | F_PCI), ALL, "hlt_t1");
    cyc(0, 16'h7001, 4'b0000, ex(3'd2, 3'd5, 3'd0, F_ARW), ALL, "hlt_t2");
    cyc(0, 16'h7001, 4'b0000, ex(3'd3, 3'd0, 3'd0, '0), ALL, "hlt_t3");
    for (int k = 0; k < 10; k++)
      cyc(0, 16'h7001, 4'b0000, ex(3'd0, 3'd0, 3'd0, F_HLT), ALL, $sformatf("halt_hold%0d", k));
    cyc(1, 16'h7001, 4'b0000, ex(3'd0, 3'd0, 3'd0, F_RST), ALL, "halt_reset");

    cyc(0, 16'h6105, 4'b0010, ex(3'd0, 3'd2, 3'd0, F_ARW), ALL, "halt_refetch");
    cyc(0, 16'h6105, 4'b0010, ex(3'd1, 3'd7, 3'd0, F_IRW | F_PCI), ALL, "isz_rst_t1");
    cyc(0, 16'h6105, 4'b0010, ex(3'd2, 3'd5, 3'd0, F_ARW), ALL, "isz_rst_t2");
    cyc(0, 16'h6105, 4'b0010, ex(3'd3, 3'd0, 3'd0, '0), ALL, "isz_rst_t3");
    cyc(0, 16'h6105, 4'b0010, ex(3'd4, 3'd7, 3'd0, F_DRW), ALL, "isz_rst_t4");
    cyc(1, 16'h6105, 4'b0010, ex(3'd0, 3'd0, 3'd0, F_RST), NO_T, "isz_rst_t5");
    cyc(0, 16'h2105, 4'b0010, ex(3'd0, 3'd2, 3'd0, F_ARW), ALL, "isz_rst_after_t0");
    cyc(0, 16'h2105, 4'b0010, ex(3'd1, 3'd7, 3'd0, F_IRW | F_PCI), ALL, "isz_rst_after_t1");
    cyc(0, 16'h2105, 4'b0010, ex(3'd2, 3'd5, 3'd0, F_ARW), ALL, "isz_rst_after_t2");
    cyc(0, 16'h2105, 4'b0010, ex(3'd3, 3'd0, 3'd0, '0), ALL, "isz_rst_after_t3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
